// File: rtl/pcs_pkg.sv
// Shared 64b/66b PCS definitions: sync-header encodings and block-lock FSM states.
package pcs_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    typedef enum logic [1:0] {
        LOCK_INIT = 2'd0,
        TEST_SH   = 2'd1,
        SLIP      = 2'd2,
        SLIP_WAIT = 2'd3
    } block_lock_state_t;

    function automatic logic is_legal_header(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/rx_block_lock.sv
// 64b/66b receive block-lock FSM: counts legal sync headers, declares lock after a
// clean window, and requests single-bit slips when alignment is wrong or lost.
module rx_block_lock
    import pcs_pkg::*;
#(
    parameter int SH_CNT_MAX       = 64,
    parameter int SH_INVALID_MAX   = 16,
    parameter int SLIP_WAIT_CYCLES = 32
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [1:0] i_header,
    input  logic       i_header_valid,
    output logic       o_slip,
    output logic       o_block_lock
);

    localparam int CNT_W = $clog2(SH_CNT_MAX + 1);
    localparam int INV_W = $clog2(SH_INVALID_MAX + 1);

    block_lock_state_t r_state;
    block_lock_state_t w_state_nxt;
    logic [CNT_W-1:0]  r_sh_cnt;
    logic [CNT_W-1:0]  w_sh_cnt_nxt;
    logic [CNT_W-1:0]  w_n_cnt;
    logic [INV_W-1:0]  r_inv_cnt;
    logic [INV_W-1:0]  w_inv_cnt_nxt;
    logic [INV_W-1:0]  w_n_inv;
    logic [7:0]        r_wait_cnt;
    logic [7:0]        w_wait_cnt_nxt;
    logic              r_slip;
    logic              w_slip_nxt;
    logic              r_lock;
    logic              w_lock_nxt;
    logic              w_illegal;

    assign w_illegal = !is_legal_header(i_header);
    assign w_n_cnt   = r_sh_cnt + CNT_W'(1);
    assign w_n_inv   = r_inv_cnt + {{(INV_W-1){1'b0}}, w_illegal};

    always_comb begin
        w_state_nxt    = r_state;
        w_sh_cnt_nxt   = r_sh_cnt;
        w_inv_cnt_nxt  = r_inv_cnt;
        w_wait_cnt_nxt = r_wait_cnt;
        w_slip_nxt     = 1'b0;
        w_lock_nxt     = r_lock;

        case (r_state)
            LOCK_INIT: begin
                w_sh_cnt_nxt   = '0;
                w_inv_cnt_nxt  = '0;
                w_wait_cnt_nxt = '0;
                w_lock_nxt     = 1'b0;
                w_state_nxt    = TEST_SH;
            end
            TEST_SH: begin
                if (i_header_valid) begin
                    // Unlocked: any bad header slips; locked: only a saturated window does.
                    if (w_illegal && (!r_lock || (w_n_inv == INV_W'(SH_INVALID_MAX)))) begin
                        w_state_nxt   = SLIP;
                        w_slip_nxt    = 1'b1;
                        w_lock_nxt    = 1'b0;
                        w_sh_cnt_nxt  = '0;
                        w_inv_cnt_nxt = '0;
                    end else if (w_n_cnt == CNT_W'(SH_CNT_MAX)) begin
                        if (w_n_inv == '0) begin
                            w_lock_nxt = 1'b1;
                        end
                        w_sh_cnt_nxt  = '0;
                        w_inv_cnt_nxt = '0;
                    end else begin
                        w_sh_cnt_nxt  = w_n_cnt;
                        w_inv_cnt_nxt = w_n_inv;
                    end
                end
            end
            SLIP: begin
                w_sh_cnt_nxt   = '0;
                w_inv_cnt_nxt  = '0;
                w_wait_cnt_nxt = '0;
                w_lock_nxt     = 1'b0;
                w_state_nxt    = SLIP_WAIT;
            end
            SLIP_WAIT: begin
                // Give the transceiver time to apply the slip before judging headers again.
                if (r_wait_cnt == 8'(SLIP_WAIT_CYCLES - 1)) begin
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = TEST_SH;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = LOCK_INIT;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= LOCK_INIT;
            r_sh_cnt   <= '0;
            r_inv_cnt  <= '0;
            r_wait_cnt <= '0;
            r_slip     <= 1'b0;
            r_lock     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sh_cnt   <= w_sh_cnt_nxt;
            r_inv_cnt  <= w_inv_cnt_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_slip     <= w_slip_nxt;
            r_lock     <= w_lock_nxt;
        end
    end

    assign o_slip       = r_slip;
    assign o_block_lock = r_lock;

endmodule

// File: doc/rx_block_lock.md
# rx_block_lock

Receive-side 64b/66b block-lock state machine (IEEE 802.3 Clause 49.2.13.2.2), sitting directly downstream of `rx_gearbox`. It inspects every 2-bit sync header the gearbox marks valid and declares `o_block_lock` once 64 consecutive headers are legal. It drives a one-cycle slip request back to the transceiver/gearbox to shift alignment by one bit when lock is not achieved or is lost. Its lock output gates the downstream descrambler and decoder.

## Interface
- `SH_CNT_MAX`, default 64: headers per evaluation window.
- `SH_INVALID_MAX`, default 16: invalid headers in one window that drop lock.
- `SLIP_WAIT_CYCLES`, default 32: cycles headers are ignored after a slip; legal range 1–255.

Ports:
- `i_clk`  in  1  single clock, the gearbox/PCS RX user clock.
- `i_reset_n`  in  1  asynchronous, active-low reset; one clock domain only.
- `i_header`  in  2  sync header from `rx_gearbox` `o_header`.
- `i_header_valid`  in  1  qualifies `i_header`; connected to `rx_gearbox` `o_header_valid`.
- `o_slip`  out  1  single-cycle bit-slip request to the transceiver.
- `o_block_lock`  out  1  block lock achieved.

## Operation
- Legal header: `2'b01` (data) or `2'b10` (control). Illegal header: `2'b00` or `2'b11`.
- Internal counters:
  - `sh_cnt` is $clog2(SH_CNT_MAX+1) bits.
  - `sh_invalid_cnt` is $clog2(SH_INVALID_MAX+1) bits.
  - `wait_cnt` is 8 bits.
- States:
  - LOCK_INIT: entered on reset; clears all counters and `o_block_lock`; moves to TEST_SH on the next cycle.
  - TEST_SH: waits for `i_header_valid`. Headers with `i_header_valid`=0 are ignored.
  - SLIP: lasts one cycle; `o_slip`=1, counters cleared, `o_block_lock`=0. Moves to SLIP_WAIT.
  - SLIP_WAIT: headers are ignored. `wait_cnt` counts 0..SLIP_WAIT_CYCLES-1, then the state returns to TEST_SH.
- On each valid header in TEST_SH, form next counts: `n_cnt = sh_cnt+1`; `n_inv = sh_invalid_cnt + illegal`. Evaluate in this priority order:
  1. Illegal and (`o_block_lock`=0 or `n_inv == SH_INVALID_MAX`): go to SLIP.
  2. Otherwise, if `n_cnt == SH_CNT_MAX`: if `n_inv==0`, set `o_block_lock`=1. In either case clear both counters and stay in TEST_SH. A locked window with 1..SH_INVALID_MAX-1 illegal headers keeps lock.
  3. Otherwise, store `n_cnt` and `n_inv`.
- When unlocked, any illegal header slips immediately. An unlocked window therefore only completes with `n_inv==0`.

## Timing
- All outputs are registered.
- Reset values: `o_slip`=0, `o_block_lock`=0, state LOCK_INIT.
- Reset asserted mid-operation immediately clears outputs and counters. This includes a reset arriving during SLIP or SLIP_WAIT.
- `o_block_lock` rises one cycle after the edge sampling the 64th consecutive legal valid header.
- `o_block_lock` falls in the same cycle that `o_slip` is high.
- `o_slip` is high for exactly one cycle. That cycle immediately follows the edge that sampled the triggering header.
- Slip spacing: the next slip comes no earlier than 2+SLIP_WAIT_CYCLES cycles after the previous one. This lets the transceiver complete the previous slip.
- If `i_header_valid` is high in SLIP or SLIP_WAIT, the header has no effect on counters.
- `i_header_valid` gaps (gearbox pause / data-only cycles) freeze the counters; the window is measured in headers, not cycles.

## Structure
- Shared package `pcs_pkg` holds:
  - `SYNC_DATA` = 2'b01 and `SYNC_CTRL` = 2'b10, also used by the decoder.
  - typedef enum `block_lock_state_t` {LOCK_INIT, TEST_SH, SLIP, SLIP_WAIT}.
- Single module with no sub-module. The state register, three counters and the output registers fit in one always_ff with a combinational next-count block.

## Test plan
- Reset, then 64 valid headers of 2'b01 interleaved with `i_header_valid` gaps: `o_block_lock`=0 through header 63 and 1 the cycle after the 64th; `o_slip` never asserts.
- Unlocked; feed 2'b11 as the 10th valid header: `o_slip`=1 for one cycle, next cycle 0. Headers are ignored for 32 cycles. Counting restarts from 0 afterwards, and 64 further legal headers are needed for lock.
- Locked; inject 15 illegal headers (2'b00) within one 64-header window: lock held, no slip. At the window end the counters reset, and 15 more illegal headers still hold lock.
- Locked; inject 16 illegal headers in one window: `o_slip` pulses on the 16th and `o_block_lock` falls in the same cycle.
- Free-running misaligned stream (random headers) with a model that shifts alignment on each `o_slip`: lock is achieved after at most 66 slips; consecutive slips are ≥34 cycles apart.
- Assert `i_reset_n`=0 during SLIP_WAIT and while locked: outputs are 0 immediately (asynchronously). After release, behaviour matches a fresh reset.
